// File: rtl/soc_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : soc_bus_arbiter_pkg
// Description : Shared state encoding, error codes and helpers for the
//               soc_bus_arbiter interconnect.
// Revision    : 1.0 - initial release
// ============================================================================
package soc_bus_arbiter_pkg;

    localparam int C_SEL_BITS_DEFAULT = 4;
    localparam int C_WD_W             = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic C_ERR_NONE  = 1'b0;
    localparam logic C_ERR_FAULT = 1'b1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/soc_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : soc_bus_arbiter_if
// Description : Master-side and slave-side bus signals of the interconnect.
// Revision    : 1.0 - initial release
// ============================================================================
interface soc_bus_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
);
    logic [NUM_MASTERS-1:0]        m_req_i;
    logic [NUM_MASTERS-1:0]        m_we_i;
    logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i;
    logic [NUM_MASTERS*DATA_W-1:0] m_wdata_i;
    logic [NUM_MASTERS-1:0]        m_gnt_o;
    logic [NUM_MASTERS-1:0]        m_rvalid_o;
    logic [DATA_W-1:0]             m_rdata_o;
    logic                          m_err_o;

    logic [NUM_SLAVES-1:0]         s_sel_o;
    logic                          s_we_o;
    logic [ADDR_W-1:0]             s_addr_o;
    logic [DATA_W-1:0]             s_wdata_o;
    logic [NUM_SLAVES*DATA_W-1:0]  s_rdata_i;
    logic [NUM_SLAVES-1:0]         s_ready_i;

    // View of the requesting cores
    modport master (
        output m_req_i, m_we_i, m_addr_i, m_wdata_i,
        input  m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o
    );

    // View of the memory-mapped targets
    modport slave (
        input  s_sel_o, s_we_o, s_addr_o, s_wdata_o,
        output s_rdata_i, s_ready_i
    );

    modport arbiter (
        input  m_req_i, m_we_i, m_addr_i, m_wdata_i, s_rdata_i, s_ready_i,
        output m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o,
        output s_sel_o, s_we_o, s_addr_o, s_wdata_o
    );
endinterface
`default_nettype wire

// File: rtl/soc_bus_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : soc_bus_arbiter_rr_arbiter
// Description : Round-robin pick: first requester after i_ptr, with wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module soc_bus_arbiter_rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = 1
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IDX_W-1:0]       i_ptr,
    output logic [NUM_MASTERS-1:0] o_gnt,
    output logic [IDX_W-1:0]       o_idx,
    output logic                   o_any
);
    int w_dist;
    int w_best;

    // Distance from the pointer decides priority; the closest requester wins.
    always_comb begin
        w_best = NUM_MASTERS;
        w_dist = 0;
        o_idx  = '0;
        o_any  = 1'b0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            w_dist = (j + 2 * NUM_MASTERS - int'(i_ptr) - 1) % NUM_MASTERS;
            if (i_req[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_idx  = IDX_W'(j);
                o_any  = 1'b1;
            end
        end
    end

    always_comb begin
        o_gnt = '0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            o_gnt[j] = o_any && (o_idx == IDX_W'(j));
        end
    end

endmodule
`default_nettype wire

// File: rtl/soc_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : soc_bus_arbiter
// Description : Round-robin, single-outstanding memory-mapped interconnect
//               with address decode and slave watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module soc_bus_arbiter
    import soc_bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int SEL_BITS    = C_SEL_BITS_DEFAULT,
    parameter int TIMEOUT     = 255
) (
    input  logic                clk,
    input  logic                rst,
    soc_bus_arbiter_if.arbiter  bus
);
    localparam int                    C_MIDX_W      = idx_width(NUM_MASTERS);
    localparam logic [C_MIDX_W-1:0]   C_PTR_RST     = C_MIDX_W'(NUM_MASTERS - 1);
    localparam logic [C_WD_W-1:0]     C_TIMEOUT_CNT = C_WD_W'(TIMEOUT);
    localparam logic [NUM_SLAVES-1:0] C_SEL_ONE     = NUM_SLAVES'(1);

    state_t                  r_state;
    logic [C_MIDX_W-1:0]     r_rr_ptr;
    logic [C_MIDX_W-1:0]     r_win_idx;
    logic [NUM_MASTERS-1:0]  r_win_oh;
    logic [C_WD_W-1:0]       r_wd_cnt;
    logic [ADDR_W-1:0]       r_addr;
    logic                    r_we;
    logic [DATA_W-1:0]       r_wdata;
    logic [NUM_SLAVES-1:0]   r_sel;
    logic [NUM_MASTERS-1:0]  r_gnt;
    logic [NUM_MASTERS-1:0]  r_rvalid;
    logic [DATA_W-1:0]       r_rdata;
    logic                    r_err;

    logic [NUM_MASTERS-1:0]  w_arb_gnt;
    logic [C_MIDX_W-1:0]     w_arb_idx;
    logic                    w_arb_any;
    logic [ADDR_W-1:0]       w_req_addr;
    logic [DATA_W-1:0]       w_req_wdata;
    logic                    w_req_we;
    logic [SEL_BITS-1:0]     w_req_slv;
    logic                    w_dec_ok;
    logic                    w_slv_ready;
    logic [DATA_W-1:0]       w_slv_rdata;
    logic [C_WD_W-1:0]       w_wd_next;

    soc_bus_arbiter_rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (C_MIDX_W)
    ) u_rr_arbiter (
        .i_req (bus.m_req_i),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    always_comb begin
        w_req_addr  = '0;
        w_req_wdata = '0;
        w_req_we    = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (w_arb_gnt[k]) begin
                w_req_addr  = bus.m_addr_i[k*ADDR_W +: ADDR_W];
                w_req_wdata = bus.m_wdata_i[k*DATA_W +: DATA_W];
                w_req_we    = bus.m_we_i[k];
            end
        end
    end

    assign w_req_slv = w_req_addr[ADDR_W-1 -: SEL_BITS];
    assign w_dec_ok  = (32'(w_req_slv) < 32'(NUM_SLAVES));

    // Only the selected slave's ready and data are observed.
    always_comb begin
        w_slv_rdata = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            if (r_sel[s]) begin
                w_slv_rdata = bus.s_rdata_i[s*DATA_W +: DATA_W];
            end
        end
    end

    assign w_slv_ready = |(bus.s_ready_i & r_sel);
    assign w_wd_next   = r_wd_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= C_PTR_RST;
            r_win_idx <= '0;
            r_win_oh  <= '0;
            r_wd_cnt  <= '0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_sel     <= '0;
            r_gnt     <= '0;
            r_rvalid  <= '0;
            r_rdata   <= '0;
            r_err     <= C_ERR_NONE;
        end else begin
            r_gnt    <= '0;
            r_rvalid <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_any) begin
                        r_win_idx <= w_arb_idx;
                        r_win_oh  <= w_arb_gnt;
                        r_gnt     <= w_arb_gnt;
                        r_addr    <= w_req_addr;
                        r_we      <= w_req_we;
                        r_wdata   <= w_req_wdata;
                        r_wd_cnt  <= '0;
                        if (w_dec_ok) begin
                            r_sel   <= C_SEL_ONE << w_req_slv;
                            r_state <= ST_ACCESS;
                        end else begin
                            // Unmapped target: respond at once, slave untouched
                            r_rvalid <= w_arb_gnt;
                            r_rdata  <= '0;
                            r_err    <= C_ERR_FAULT;
                            r_state  <= ST_RESP;
                        end
                    end
                end
                ST_ACCESS: begin
                    r_wd_cnt <= w_wd_next;
                    if (w_slv_ready) begin
                        r_sel    <= '0;
                        r_rdata  <= r_we ? '0 : w_slv_rdata;
                        r_err    <= C_ERR_NONE;
                        r_rvalid <= r_win_oh;
                        r_state  <= ST_RESP;
                    end else if (w_wd_next == C_TIMEOUT_CNT) begin
                        r_sel    <= '0;
                        r_rdata  <= '0;
                        r_err    <= C_ERR_FAULT;
                        r_rvalid <= r_win_oh;
                        r_state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_rr_ptr <= r_win_idx;
                    r_wd_cnt <= '0;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.m_gnt_o    = r_gnt;
    assign bus.m_rvalid_o = r_rvalid;
    assign bus.m_rdata_o  = r_rdata;
    assign bus.m_err_o    = r_err;
    assign bus.s_sel_o    = r_sel;
    assign bus.s_we_o     = r_we;
    assign bus.s_addr_o   = r_addr;
    assign bus.s_wdata_o  = r_wdata;

endmodule
`default_nettype wire
